ifmap_fifo_unit: RTL and testbench
==================================

# ifmap_fifo_unit

Input-feature-map staging block between the global buffer (GLB) and the PE array. A control FSM (`ifmap_fifo_ctrl`) turns a pop task into GLB word/byte reads and pushes the results into a byte-wide FIFO (`ifmap_fifo`). The FIFO then delivers exactly the requested number of bytes to the consumer and raises done.

## Interface
- `DEPTH`, 16: FIFO depth in bytes (power of 2, ≥8).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ifmap_fifo_reset_i`  in  1  synchronous soft clear of FIFO and FSM.
- `ifmap_need_pop_i`  in  1  task-start strobe, sampled in IDLE/DONE.
- `ifmap_pop_num_i`  in  5  number of bytes in the task (0–31).
- `ifmap_permit_push_i`  in  1  GLB read port granted this cycle.
- `ifmap_glb_base_addr_i`  in  32  task byte base address, latched at start.
- `ifmap_glb_read_data_i`  in  32  GLB read data, valid 1 cycle after request.
- `ifmap_fifo_reset_o`  out  1  equals `ifmap_fifo_reset_i`, combinational.
- `ifmap_glb_read_req_o`  out  1  GLB read request.
- `ifmap_glb_read_addr_o`  out  32  GLB byte address.
- `ifmap_fifo_pop_en_o`  out  1  a byte is delivered this cycle.
- `ifmap_pop_data_o`  out  8  delivered byte, valid when pop_en=1.
- `ifmap_fifo_done_o`  out  1  task complete (level).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with `need_pop_i=1`: latch base address; set `push_rem = pop_rem = pop_num`; clear the address offset; go to RUN.
  - RUN with `pop_rem==0`: go to DONE.
  - DONE: `done_o=1`. Hold until the next `need_pop_i`, `fifo_reset_i`, or `rst_n`.
- Read issue (RUN): `read_req_o = permit_push_i && push_rem>0 && !full`.
  - Address is `base + offset`.
  - Word mode when `push_rem ≥ 4`: offset += 4, push_rem −= 4.
  - Byte mode otherwise: offset += 1, push_rem −= 1.
  - The mode is registered alongside the request.
- Push: the cycle after a request, `push_en=1` and `push_data = read_data_i`.
  - `push_mod=1` (word) writes 4 bytes, little-endian: [7:0] first, [31:24] last.
  - `push_mod=0` (byte) writes [7:0] only.
  - Every task therefore pushes exactly `pop_num` bytes.
- Pop (RUN): `pop_en_o = pop_rem>0 && !empty`. Each pop decrements pop_rem.
- FIFO behaviour:
  - First-word fall-through: `pop_data_o` is the head byte, combinational.
  - `empty = (count==0)`.
  - `full = (DEPTH − count < 8)`. This guarantees both an in-flight word and a new word fit.
  - Push and pop may occur in the same cycle. Count updates by +N−1.
  - Pop on empty is ignored. Push that does not fit is dropped; it is unreachable when full is honoured.
- `pop_num=0`: RUN lasts one cycle, then DONE. No reads, no pops.
- `fifo_reset_i=1`: next edge clears pointers/count, FSM → IDLE, done=0, in-flight push discarded. This has priority over `need_pop_i`.
- `need_pop_i` during RUN is ignored.
- Offset and address arithmetic are 32-bit and wrap modulo 2^32.

## Timing
- Reset values:
  - All outputs 0 except `empty=1`.
  - `read_addr_o` = 0 in IDLE. In RUN it is `base + offset`; only its value while `read_req_o=1` is defined.
- Start latency: `need_pop_i` at edge T → RUN in cycle T+1. The first read_req is possible in T+1.
- GLB latency is exactly 1 cycle. Back-to-back requests are allowed.
- The first pop is possible 2 cycles after its read_req, once the pushed data has been written.
- `done_o` rises the cycle after the final pop.
- `rst_n` low at any time clears all state immediately, mid-task included.

## Structure
- Shared package `ifmap_pkg`:
  - FSM state enum.
  - `PUSH_BYTE`/`PUSH_WORD` constants.
  - `GLB_RD_LATENCY=1`.
  - Full-threshold constant (8).
- `ifmap_fifo_unit` instantiates two sub-modules:
  - `ifmap_fifo_ctrl`: FSM, counters, address generation.
  - `ifmap_fifo`: byte RAM, pointers, count, full/empty; sync clear from `ifmap_fifo_reset_o`.

## Test plan
- Base 0x1000, pop_num=6, permit held 1, read data 0xCAFEBABE then 0x11223344 then 0x55667788:
  - Reads at 0x1000 (word), 0x1004 (byte), 0x1005 (byte).
  - Pops BE, BA, FE, CA, 44, 88.
  - done=1; FIFO empty.
- pop_num=0 → done rises 2 cycles after need_pop; no read_req, no pop_en.
- permit_push held 0 for 10 cycles, then 1 → no reads while 0. Task completes afterwards; done only after 31 pops when pop_num=31.
- pop_num=16, permit always 1 → full asserts when ≥9 bytes are buffered. No push is dropped; all 16 bytes pop in order.
- `fifo_reset_i` pulse mid-task → next cycle IDLE, empty=1, done=0. A new task then runs cleanly.
- `rst_n` asserted mid-push → all outputs 0 immediately; subsequent task correct.

Source files
------------

// File: rtl/ifmap_pkg.sv
// rtl/ifmap_pkg.sv - shared types and constants for the ifmap staging block
// Contents:
//   ifmap_state_e      control FSM state encoding
//   PUSH_BYTE/PUSH_WORD push width select carried with each GLB read
//   GLB_RD_LATENCY     cycles from read request to valid read data
//   FULL_THRESH        minimum free bytes needed to accept another read
//   WORD_BYTES         bytes in one GLB word
package ifmap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ifmap_state_e;

    localparam logic PUSH_BYTE      = 1'b0;
    localparam logic PUSH_WORD      = 1'b1;
    localparam int   GLB_RD_LATENCY = 1;
    localparam int   FULL_THRESH    = 8;
    localparam int   WORD_BYTES     = 4;

endpackage

// File: rtl/ifmap_fifo.sv
// rtl/ifmap_fifo.sv - byte-wide first-word-fall-through FIFO with 1- or 4-byte pushes
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr_i          synchronous clear of pointers and count
//   push_en_i      write push_data_i this cycle
//   push_mod_i     PUSH_WORD writes 4 bytes little-endian, PUSH_BYTE writes [7:0]
//   push_data_i    GLB read word
//   pop_en_i       consume the head byte
//   pop_data_o     head byte (combinational)
//   empty_o/full_o occupancy flags
module ifmap_fifo
    import ifmap_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        push_en_i,
    input  logic        push_mod_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_en_i,
    output logic [7:0]  pop_data_o,
    output logic        empty_o,
    output logic        full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] push_n;
    logic [CW-1:0] free_n;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        push_n   = (push_mod_i == PUSH_WORD) ? CW'(WORD_BYTES) : CW'(1);
        free_n   = CW'(DEPTH) - count_q;
        // Free space is judged before this cycle's pop, so an oversize push is
        // dropped whole rather than partially written.
        push_ok  = push_en_i && (free_n >= push_n);
        pop_ok   = pop_en_i && (count_q != '0);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(push_n) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + (push_ok ? push_n : CW'(0)) - CW'(pop_ok);
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only bytes covered by count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok && !clr_i) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (b == 0 || push_mod_i == PUSH_WORD) begin
                    mem_q[wr_ptr_q + AW'(b)] <= push_data_i[8*b +: 8];
                end
            end
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    // Leaving room for FULL_THRESH bytes covers a word already in flight plus
    // a word requested in the same cycle.
    assign full_o     = (CW'(DEPTH) - count_q) < CW'(FULL_THRESH);

endmodule

// File: rtl/ifmap_fifo_ctrl.sv
// rtl/ifmap_fifo_ctrl.sv - task FSM, GLB read issue and pop accounting
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   soft_clr_i      synchronous return to IDLE, drops in-flight push
//   need_pop_i      task start, honoured in IDLE/DONE
//   pop_num_i       bytes in the task
//   permit_push_i   GLB read port granted
//   base_addr_i     task byte base address
//   fifo_full_i/fifo_empty_i  FIFO flags
//   read_req_o/read_addr_o    GLB read request and byte address
//   push_en_o/push_mod_o      FIFO push for the request of the previous cycle
//   pop_en_o        deliver one byte this cycle
//   done_o          task complete
module ifmap_fifo_ctrl
    import ifmap_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        soft_clr_i,
    input  logic        need_pop_i,
    input  logic [4:0]  pop_num_i,
    input  logic        permit_push_i,
    input  logic [31:0] base_addr_i,
    input  logic        fifo_full_i,
    input  logic        fifo_empty_i,
    output logic        read_req_o,
    output logic [31:0] read_addr_o,
    output logic        push_en_o,
    output logic        push_mod_o,
    output logic        pop_en_o,
    output logic        done_o
);

    ifmap_state_e state_q, state_d;
    logic [31:0]  base_q, base_d;
    logic [31:0]  offset_q, offset_d;
    logic [4:0]   push_rem_q, push_rem_d;
    logic [4:0]   pop_rem_q, pop_rem_d;
    logic         push_en_q, push_en_d;
    logic         push_mod_q, push_mod_d;
    logic         done_q, done_d;
    logic         run;
    logic         word_mode;

    always_comb begin
        run        = (state_q == ST_RUN);
        word_mode  = (push_rem_q >= 5'd4);
        read_req_o = run && permit_push_i && (push_rem_q != 5'd0) && !fifo_full_i;
        pop_en_o   = run && (pop_rem_q != 5'd0) && !fifo_empty_i;

        state_d    = state_q;
        base_d     = base_q;
        offset_d   = offset_q;
        push_rem_d = push_rem_q;
        pop_rem_d  = pop_rem_q;
        done_d     = done_q;
        push_en_d  = read_req_o;
        push_mod_d = word_mode ? PUSH_WORD : PUSH_BYTE;

        if (read_req_o) begin
            offset_d   = offset_q + (word_mode ? 32'd4 : 32'd1);
            push_rem_d = push_rem_q - (word_mode ? 5'd4 : 5'd1);
        end
        if (pop_en_o) begin
            pop_rem_d = pop_rem_q - 5'd1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (need_pop_i) begin
                    state_d    = ST_RUN;
                    base_d     = base_addr_i;
                    offset_d   = 32'd0;
                    push_rem_d = pop_num_i;
                    pop_rem_d  = pop_num_i;
                    done_d     = 1'b0;
                end
            end
            ST_RUN: begin
                // Looking at the post-pop count lets done rise right after the
                // final pop instead of one cycle later.
                if (pop_rem_d == 5'd0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (soft_clr_i) begin
            state_d    = ST_IDLE;
            offset_d   = 32'd0;
            push_rem_d = 5'd0;
            pop_rem_d  = 5'd0;
            push_en_d  = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= 32'd0;
            offset_q   <= 32'd0;
            push_rem_q <= 5'd0;
            pop_rem_q  <= 5'd0;
            push_en_q  <= 1'b0;
            push_mod_q <= PUSH_BYTE;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            offset_q   <= offset_d;
            push_rem_q <= push_rem_d;
            pop_rem_q  <= pop_rem_d;
            push_en_q  <= push_en_d;
            push_mod_q <= push_mod_d;
            done_q     <= done_d;
        end
    end

    assign read_addr_o = run ? (base_q + offset_q) : 32'd0;
    assign push_en_o   = push_en_q;
    assign push_mod_o  = push_mod_q;
    assign done_o      = done_q;

endmodule

// File: rtl/ifmap_fifo_unit.sv
// rtl/ifmap_fifo_unit.sv - ifmap staging between GLB and PE array
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifmap_fifo_reset_i/_o      soft clear in, forwarded out combinationally
//   ifmap_need_pop_i           task start strobe
//   ifmap_pop_num_i            bytes in the task (0-31)
//   ifmap_permit_push_i        GLB read port granted
//   ifmap_glb_base_addr_i      task byte base address
//   ifmap_glb_read_data_i      GLB data, one cycle after request
//   ifmap_glb_read_req_o/addr  GLB read request and byte address
//   ifmap_fifo_pop_en_o        byte delivered this cycle
//   ifmap_pop_data_o           delivered byte
//   ifmap_fifo_done_o          task complete
module ifmap_fifo_unit
    import ifmap_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifmap_fifo_reset_i,
    input  logic        ifmap_need_pop_i,
    input  logic [4:0]  ifmap_pop_num_i,
    input  logic        ifmap_permit_push_i,
    input  logic [31:0] ifmap_glb_base_addr_i,
    input  logic [31:0] ifmap_glb_read_data_i,
    output logic        ifmap_fifo_reset_o,
    output logic        ifmap_glb_read_req_o,
    output logic [31:0] ifmap_glb_read_addr_o,
    output logic        ifmap_fifo_pop_en_o,
    output logic [7:0]  ifmap_pop_data_o,
    output logic        ifmap_fifo_done_o
);

    logic       push_en;
    logic       push_mod;
    logic       pop_en;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] head_byte;

    assign ifmap_fifo_reset_o = ifmap_fifo_reset_i;

    ifmap_fifo_ctrl u_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .soft_clr_i    (ifmap_fifo_reset_i),
        .need_pop_i    (ifmap_need_pop_i),
        .pop_num_i     (ifmap_pop_num_i),
        .permit_push_i (ifmap_permit_push_i),
        .base_addr_i   (ifmap_glb_base_addr_i),
        .fifo_full_i   (fifo_full),
        .fifo_empty_i  (fifo_empty),
        .read_req_o    (ifmap_glb_read_req_o),
        .read_addr_o   (ifmap_glb_read_addr_o),
        .push_en_o     (push_en),
        .push_mod_o    (push_mod),
        .pop_en_o      (pop_en),
        .done_o        (ifmap_fifo_done_o)
    );

    ifmap_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (ifmap_fifo_reset_o),
        .push_en_i   (push_en),
        .push_mod_i  (push_mod),
        .push_data_i (ifmap_glb_read_data_i),
        .pop_en_i    (pop_en),
        .pop_data_o  (head_byte),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Head storage is unreset, so the byte is only driven while it is delivered.
    assign ifmap_fifo_pop_en_o = pop_en;
    assign ifmap_pop_data_o    = pop_en ? head_byte : 8'h00;

endmodule

// File: tb/tb_ifmap_fifo_unit.sv
// tb/tb_ifmap_fifo_unit.sv - self-checking bench for ifmap_fifo_unit
module tb_ifmap_fifo_unit;
    import ifmap_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifmap_fifo_reset_i;
    logic        ifmap_need_pop_i;
    logic [4:0]  ifmap_pop_num_i;
    logic        ifmap_permit_push_i;
    logic [31:0] ifmap_glb_base_addr_i;
    logic [31:0] ifmap_glb_read_data_i;
    logic        ifmap_fifo_reset_o;
    logic        ifmap_glb_read_req_o;
    logic [31:0] ifmap_glb_read_addr_o;
    logic        ifmap_fifo_pop_en_o;
    logic [7:0]  ifmap_pop_data_o;
    logic        ifmap_fifo_done_o;

    ifmap_fifo_unit #(.DEPTH(DEPTH)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ifmap_fifo_reset_i    (ifmap_fifo_reset_i),
        .ifmap_need_pop_i      (ifmap_need_pop_i),
        .ifmap_pop_num_i       (ifmap_pop_num_i),
        .ifmap_permit_push_i   (ifmap_permit_push_i),
        .ifmap_glb_base_addr_i (ifmap_glb_base_addr_i),
        .ifmap_glb_read_data_i (ifmap_glb_read_data_i),
        .ifmap_fifo_reset_o    (ifmap_fifo_reset_o),
        .ifmap_glb_read_req_o  (ifmap_glb_read_req_o),
        .ifmap_glb_read_addr_o (ifmap_glb_read_addr_o),
        .ifmap_fifo_pop_en_o   (ifmap_fifo_pop_en_o),
        .ifmap_pop_data_o      (ifmap_pop_data_o),
        .ifmap_fifo_done_o     (ifmap_fifo_done_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [31:0] exp_addr [$];
    int          exp_sz   [$];
    logic [7:0]  exp_pop  [$];
    logic [7:0]  obs_pop  [$];
    logic [31:0] glb_q    [$];
    int          occ = 0;
    int          pend_sz = 0;
    int          reads_seen = 0;
    int          pops_seen = 0;
    int          n_reads_exp = 0;
    int          cyc = 0;
    int          last_pop_cyc = 0;
    int          done_rise_cyc = -1;
    int          start_cyc = 0;
    logic        done_prev = 1'b0;
    logic        saw_full = 1'b0;
    logic [31:0] rd_word_next = 32'h0;
    int          perm_mode = 0;   // 0: always granted, 1: never, 2: random

    // GLB model and grant driver: data answers the previous cycle's request.
    always @(posedge clk) begin
        cyc++;
        #1;
        ifmap_glb_read_data_i = rd_word_next;
        case (perm_mode)
            0:       ifmap_permit_push_i = 1'b1;
            1:       ifmap_permit_push_i = 1'b0;
            default: ifmap_permit_push_i = 1'($urandom_range(0, 1));
        endcase
    end

    // Observer: checks reads, pops and FIFO occupancy against the model.
    always @(negedge clk) begin
        int          nxt_sz;
        int          s;
        logic [31:0] w;
        if (!rst_n) begin
            exp_addr.delete(); exp_sz.delete(); exp_pop.delete();
            occ = 0; pend_sz = 0; done_prev = 1'b0;
        end else begin
            chk("full_flag", 32'(dut.u_fifo.full_o), 32'((DEPTH - occ) < FULL_THRESH));
            chk("empty_flag", 32'(dut.u_fifo.empty_o), 32'(occ == 0));
            if (dut.u_fifo.full_o) saw_full = 1'b1;
            if (ifmap_fifo_done_o && !done_prev) done_rise_cyc = cyc;
            done_prev = ifmap_fifo_done_o;
            if (ifmap_fifo_reset_i) begin
                exp_addr.delete(); exp_sz.delete(); exp_pop.delete();
                occ = 0; pend_sz = 0;
                rd_word_next = $urandom;
            end else begin
                nxt_sz = 0;
                rd_word_next = $urandom;
                if (ifmap_glb_read_req_o) begin
                    reads_seen++;
                    chk("read_expected", 32'(exp_addr.size() != 0), 32'd1);
                    if (exp_addr.size() != 0) begin
                        chk("read_addr", ifmap_glb_read_addr_o, exp_addr.pop_front());
                        s = exp_sz.pop_front();
                        w = (glb_q.size() != 0) ? glb_q.pop_front() : $urandom;
                        rd_word_next = w;
                        for (int b = 0; b < s; b++) exp_pop.push_back(w[8*b +: 8]);
                        nxt_sz = s;
                    end
                end
                if (ifmap_fifo_pop_en_o) begin
                    pops_seen++;
                    last_pop_cyc = cyc;
                    obs_pop.push_back(ifmap_pop_data_o);
                    chk("pop_expected", 32'(exp_pop.size() != 0), 32'd1);
                    if (exp_pop.size() != 0)
                        chk("pop_data", 32'(ifmap_pop_data_o), 32'(exp_pop.pop_front()));
                end
                occ = occ + pend_sz - (ifmap_fifo_pop_en_o ? 1 : 0);
                pend_sz = nxt_sz;
            end
        end
    end

    task automatic start_task(input logic [31:0] base, input int num, input int pmode);
        logic [31:0] off = 32'd0;
        int          rem = num;
        perm_mode = pmode;
        exp_addr.delete(); exp_sz.delete();
        while (rem > 0) begin
            exp_addr.push_back(base + off);
            if (rem >= 4) begin exp_sz.push_back(4); off += 4; rem -= 4; end
            else begin exp_sz.push_back(1); off += 1; rem -= 1; end
        end
        n_reads_exp = exp_addr.size();
        obs_pop.delete();
        reads_seen = 0; pops_seen = 0;
        @(posedge clk); #1;
        start_cyc = cyc;
        ifmap_need_pop_i      = 1'b1;
        ifmap_glb_base_addr_i = base;
        ifmap_pop_num_i       = 5'(num);
        @(posedge clk); #1;
        ifmap_need_pop_i      = 1'b0;
        ifmap_glb_base_addr_i = $urandom;
    endtask

    task automatic finish_task(input int num);
        logic got = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (ifmap_fifo_done_o) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        chk("done_seen", 32'(got), 32'd1);
        chk("reads_left", exp_addr.size(), 0);
        chk("pops_left", exp_pop.size(), 0);
        chk("read_count", reads_seen, n_reads_exp);
        chk("pop_count", pops_seen, num);
        chk("done_timing", done_rise_cyc, (num == 0) ? start_cyc + 2 : last_pop_cyc + 1);
        chk("empty_at_done", 32'(dut.u_fifo.empty_o), 32'd1);
    endtask

    initial begin
        logic [7:0] t1_exp [6];
        t1_exp = '{8'hBE, 8'hBA, 8'hFE, 8'hCA, 8'h44, 8'h88};

        rst_n = 1'b0;
        ifmap_fifo_reset_i    = 1'b0;
        ifmap_need_pop_i      = 1'b0;
        ifmap_pop_num_i       = 5'd0;
        ifmap_permit_push_i   = 1'b0;
        ifmap_glb_base_addr_i = 32'd0;
        ifmap_glb_read_data_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_req", 32'(ifmap_glb_read_req_o), 32'd0);
        chk("rst_read_addr", ifmap_glb_read_addr_o, 32'd0);
        chk("rst_pop_en", 32'(ifmap_fifo_pop_en_o), 32'd0);
        chk("rst_pop_data", 32'(ifmap_pop_data_o), 32'd0);
        chk("rst_done", 32'(ifmap_fifo_done_o), 32'd0);
        chk("rst_reset_o", 32'(ifmap_fifo_reset_o), 32'd0);
        chk("rst_empty", 32'(dut.u_fifo.empty_o), 32'd1);
        rst_n = 1'b1;

        // Directed task with known GLB data
        glb_q = '{32'hCAFEBABE, 32'h11223344, 32'h55667788};
        start_task(32'h1000, 6, 0);
        finish_task(6);
        chk("t1_pop_len", obs_pop.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < obs_pop.size()) chk("t1_pop_byte", 32'(obs_pop[i]), 32'(t1_exp[i]));
        chk("t1_done_level", 32'(ifmap_fifo_done_o), 32'd1);

        // Empty task
        start_task(32'h2000, 0, 0);
        finish_task(0);

        // Grant withheld for 10 cycles, then a full 31-byte task
        start_task(32'h3000, 31, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("no_read_blocked", 32'(ifmap_glb_read_req_o), 32'd0);
            chk("no_done_blocked", 32'(ifmap_fifo_done_o), 32'd0);
        end
        perm_mode = 0;
        finish_task(31);

        // Back-pressure through the full flag
        saw_full = 1'b0;
        start_task(32'h4000, 16, 0);
        finish_task(16);
        chk("saw_full", 32'(saw_full), 32'd1);

        // Soft clear mid-task
        start_task(32'h5000, 20, 0);
        repeat (3) @(posedge clk);
        #1;
        ifmap_fifo_reset_i = 1'b1;
        #1;
        chk("reset_o_follow", 32'(ifmap_fifo_reset_o), 32'd1);
        @(posedge clk); #1;
        ifmap_fifo_reset_i = 1'b0;
        chk("clr_state_idle", 32'(dut.u_ctrl.state_q), 32'(ST_IDLE));
        chk("clr_empty", 32'(dut.u_fifo.empty_o), 32'd1);
        chk("clr_done", 32'(ifmap_fifo_done_o), 32'd0);
        chk("clr_read_req", 32'(ifmap_glb_read_req_o), 32'd0);
        start_task(32'h5100, 13, 2);
        finish_task(13);

        // Asynchronous reset mid-push
        start_task(32'h6000, 24, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_read_req", 32'(ifmap_glb_read_req_o), 32'd0);
        chk("arst_read_addr", ifmap_glb_read_addr_o, 32'd0);
        chk("arst_pop_en", 32'(ifmap_fifo_pop_en_o), 32'd0);
        chk("arst_pop_data", 32'(ifmap_pop_data_o), 32'd0);
        chk("arst_done", 32'(ifmap_fifo_done_o), 32'd0);
        chk("arst_empty", 32'(dut.u_fifo.empty_o), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_task(32'h6100, 11, 0);
        finish_task(11);

        // Random tasks, including an address wrap
        start_task(32'hFFFF_FFFE, 9, 2);
        finish_task(9);
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(0, 31);
            start_task($urandom, n, 2);
            finish_task(n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
